// File: rtl/mips_pc_if.sv
// Control-flow bundle between the decode/ALU side and the program-counter unit.
// The decode side (master) drives decisions; the PC unit (slave) returns fetch state.
interface mips_pc_if;
  logic        clk_enable;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        delay_slot;
  logic        active;
  logic        addr_error;

  modport master (
    output clk_enable,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_index,
    output jump_reg,
    output reg_target,
    input  instr_address,
    input  link_address,
    input  delay_slot,
    input  active,
    input  addr_error
  );

  modport slave (
    input  clk_enable,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_index,
    input  jump_reg,
    input  reg_target,
    output instr_address,
    output link_address,
    output delay_slot,
    output active,
    output addr_error
  );
endinterface

// File: rtl/mips_pc_unit.sv
// Program counter and control-flow stage: reset vector, sequential fetch, one-slot
// branch delay, branch/jump/jump-register targets and halt when fetch reaches HALT_ADDRESS.
module mips_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input logic     clk,
  input logic     reset,
  mips_pc_if.slave pc_if
);

  typedef enum logic {
    S_SEQ  = 1'b0,
    S_SLOT = 1'b1
  } state_t;

  state_t      state_p0, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] target_p0, target_nxt;
  logic        active_p0, active_nxt;
  logic        addr_err_p0, addr_err_nxt;

  logic        step;
  logic        ctrl_req;
  logic [31:0] pc_seq;
  logic [31:0] ctrl_target;

  function automatic logic [31:0] branch_tgt(input logic [31:0] pc, input logic [15:0] off);
    logic signed [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return pc + 32'd4 + $unsigned(disp);
  endfunction

  // J/JAL keeps the 256 MB region of the delay-slot instruction, not of the jump itself.
  function automatic logic [31:0] jump_tgt(input logic [31:0] pc, input logic [25:0] idx);
    logic [31:0] seq;
    seq = pc + 32'd4;
    return {seq[31:28], idx, 2'b00};
  endfunction

  function automatic logic [31:0] reg_tgt(input logic [31:0] rt);
    return {rt[31:2], 2'b00};
  endfunction

  function automatic logic reg_misaligned(input logic [31:0] rt);
    return |rt[1:0];
  endfunction

  assign step     = pc_if.clk_enable && active_p0;
  assign ctrl_req = pc_if.jump_reg || pc_if.jump || pc_if.branch_taken;
  assign pc_seq   = pc_p0 + 32'd4;

  always_comb begin
    ctrl_target = branch_tgt(pc_p0, pc_if.branch_offset);
    if (pc_if.jump_reg) begin
      ctrl_target = reg_tgt(pc_if.reg_target);
    end else if (pc_if.jump) begin
      ctrl_target = jump_tgt(pc_p0, pc_if.jump_index);
    end
  end

  always_comb begin
    state_nxt    = state_p0;
    pc_nxt       = pc_p0;
    target_nxt   = target_p0;
    active_nxt   = active_p0;
    addr_err_nxt = addr_err_p0;
    if (step) begin
      addr_err_nxt = 1'b0;
      case (state_p0)
        S_SEQ: begin
          pc_nxt = pc_seq;
          if (ctrl_req) begin
            state_nxt    = S_SLOT;
            target_nxt   = ctrl_target;
            addr_err_nxt = pc_if.jump_reg && reg_misaligned(pc_if.reg_target);
          end
        end
        S_SLOT: begin
          // Whatever the delay-slot instruction asks for is dropped.
          pc_nxt    = target_p0;
          state_nxt = S_SEQ;
        end
        default: begin
          pc_nxt    = pc_seq;
          state_nxt = S_SEQ;
        end
      endcase
      if (pc_nxt == HALT_ADDRESS) begin
        active_nxt = 1'b0;
      end
    end
  end

  // State register: everything freezes while disabled or halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0    <= S_SEQ;
      pc_p0       <= RESET_VECTOR;
      target_p0   <= 32'h0;
      active_p0   <= 1'b1;
      addr_err_p0 <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      pc_p0       <= pc_nxt;
      target_p0   <= target_nxt;
      active_p0   <= active_nxt;
      addr_err_p0 <= addr_err_nxt;
    end
  end

  assign pc_if.instr_address = pc_p0;
  assign pc_if.link_address  = pc_p0 + 32'd8;
  assign pc_if.delay_slot    = (state_p0 == S_SLOT);
  assign pc_if.active        = active_p0;
  assign pc_if.addr_error    = addr_err_p0;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Directed bench for mips_pc_unit: a reference model checked every cycle plus literal
// expectations for each scenario.
module tb_mips_pc_unit;
  logic clk;
  logic reset;
  mips_pc_if pc_if();

  mips_pc_unit dut (
    .clk  (clk),
    .reset(reset),
    .pc_if(pc_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_slot;
  logic        m_active;
  logic        m_err;

  function automatic logic [31:0] f_target(input logic [31:0] pc, input logic jr, input logic [31:0] rt,
                                           input logic j, input logic [25:0] idx, input logic [15:0] off);
    int o;
    if (jr) return rt & 32'hFFFF_FFFC;
    if (j)  return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} << 2);
    o = $signed(off);
    return pc + 32'd4 + 32'(o * 4);
  endfunction

  function automatic logic [31:0] f_next(input logic [31:0] pc, input logic slot, input logic [31:0] tgt);
    return slot ? tgt : pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc     <= 32'hBFC0_0000;
      m_tgt    <= 32'h0;
      m_slot   <= 1'b0;
      m_active <= 1'b1;
      m_err    <= 1'b0;
    end else if (pc_if.clk_enable && m_active) begin
      m_pc     <= f_next(m_pc, m_slot, m_tgt);
      m_active <= (f_next(m_pc, m_slot, m_tgt) != 32'h0);
      if (!m_slot && (pc_if.jump_reg || pc_if.jump || pc_if.branch_taken)) begin
        m_slot <= 1'b1;
        m_tgt  <= f_target(m_pc, pc_if.jump_reg, pc_if.reg_target, pc_if.jump,
                           pc_if.jump_index, pc_if.branch_offset);
        m_err  <= pc_if.jump_reg && ((pc_if.reg_target % 4) != 0);
      end else begin
        m_slot <= 1'b0;
        m_err  <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_pc",     pc_if.instr_address, m_pc);
    chk("cyc_link",   pc_if.link_address,  m_pc + 32'd8);
    chk("cyc_slot",   {31'd0, pc_if.delay_slot}, {31'd0, m_slot});
    chk("cyc_active", {31'd0, pc_if.active},     {31'd0, m_active});
    chk("cyc_err",    {31'd0, pc_if.addr_error}, {31'd0, m_err});
  end

  task automatic clr();
    pc_if.clk_enable    = 1'b1;
    pc_if.branch_taken  = 1'b0;
    pc_if.branch_offset = 16'h0;
    pc_if.jump          = 1'b0;
    pc_if.jump_index    = 26'h0;
    pc_if.jump_reg      = 1'b0;
    pc_if.reg_target    = 32'h0;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_state(input string name, input logic [31:0] pc, input logic slot, input logic act);
    chk({name, "_pc"},     pc_if.instr_address, pc);
    chk({name, "_slot"},   {31'd0, pc_if.delay_slot}, {31'd0, slot});
    chk({name, "_active"}, {31'd0, pc_if.active},     {31'd0, act});
  endtask

  initial begin
    reset = 1'b1;
    clr();
    #12;
    reset = 1'b0;
    #1;
    // Reset state and sequential fetch.
    chk_state("rst", 32'hBFC0_0000, 1'b0, 1'b1);
    chk("rst_err",  {31'd0, pc_if.addr_error}, 32'd0);
    chk("rst_link", pc_if.link_address, 32'hBFC0_0008);
    edges(3);
    chk_state("seq3", 32'hBFC0_000C, 1'b0, 1'b1);
    chk("seq3_link", pc_if.link_address, 32'hBFC0_0014);

    // Forward branch.
    pulse_reset();
    edges(2);
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'h0004;
    edges(1); clr();
    chk_state("fwd_slot", 32'hBFC0_000C, 1'b1, 1'b1);
    edges(1);
    chk_state("fwd_tgt", 32'hBFC0_001C, 1'b0, 1'b1);

    // Backward branch.
    pulse_reset();
    edges(4);
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'hFFFF;
    edges(1); clr();
    chk_state("bwd_slot", 32'hBFC0_0014, 1'b1, 1'b1);
    edges(1);
    chk_state("bwd_tgt", 32'hBFC0_0010, 1'b0, 1'b1);

    // Branch asserted again in the delay slot is ignored.
    pulse_reset();
    edges(4);
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'hFFFF;
    edges(1);
    pc_if.branch_offset = 16'h0100;
    edges(1); clr();
    chk_state("ds_ign", 32'hBFC0_0010, 1'b0, 1'b1);
    edges(1);
    chk_state("ds_ign_next", 32'hBFC0_0014, 1'b0, 1'b1);

    // Jump.
    pulse_reset();
    pc_if.jump = 1'b1; pc_if.jump_index = 26'h000_0100;
    edges(1); clr();
    chk_state("j_slot", 32'hBFC0_0004, 1'b1, 1'b1);
    edges(1);
    chk_state("j_tgt", 32'hB000_0400, 1'b0, 1'b1);

    // Priority: jump_reg wins over jump and branch; jump wins over branch.
    pulse_reset();
    pc_if.jump_reg = 1'b1; pc_if.reg_target = 32'h1234_5670;
    pc_if.jump = 1'b1; pc_if.jump_index = 26'h000_0100;
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'h0004;
    edges(1); clr();
    edges(1);
    chk("prio_jr", pc_if.instr_address, 32'h1234_5670);
    pulse_reset();
    pc_if.jump = 1'b1; pc_if.jump_index = 26'h000_0100;
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'h0004;
    edges(1); clr();
    edges(1);
    chk("prio_j", pc_if.instr_address, 32'hB000_0400);

    // JR to zero halts.
    pulse_reset();
    edges(1);
    pc_if.jump_reg = 1'b1; pc_if.reg_target = 32'h0;
    edges(1); clr();
    chk_state("jr0_slot", 32'hBFC0_0008, 1'b1, 1'b1);
    edges(1);
    chk_state("halt", 32'h0000_0000, 1'b0, 1'b0);
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'h0004;
    edges(5); clr();
    chk_state("halt_hold", 32'h0000_0000, 1'b0, 1'b0);
    chk("halt_link", pc_if.link_address, 32'h0000_0008);

    // Misaligned JR target.
    pulse_reset();
    pc_if.jump_reg = 1'b1; pc_if.reg_target = 32'hBFC0_0103;
    edges(1); clr();
    chk("jrerr_pulse", {31'd0, pc_if.addr_error}, 32'd1);
    chk_state("jrerr_slot", 32'hBFC0_0004, 1'b1, 1'b1);
    edges(1);
    chk("jrerr_clear", {31'd0, pc_if.addr_error}, 32'd0);
    chk("jrerr_tgt", pc_if.instr_address, 32'hBFC0_0100);

    // Wrap of link and sequential fetch into the halt address.
    pulse_reset();
    pc_if.jump_reg = 1'b1; pc_if.reg_target = 32'hFFFF_FFF8;
    edges(1); clr();
    edges(1);
    chk("wrap_pc",   pc_if.instr_address, 32'hFFFF_FFF8);
    chk("wrap_link", pc_if.link_address,  32'h0000_0000);
    edges(1);
    chk("wrap_link2", pc_if.link_address, 32'h0000_0004);
    edges(1);
    chk_state("wrap_halt", 32'h0000_0000, 1'b0, 1'b0);

    // Stall with a branch pending.
    pulse_reset();
    edges(2);
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'h0004;
    edges(1); clr();
    pc_if.clk_enable = 1'b0;
    edges(2);
    chk_state("stall", 32'hBFC0_000C, 1'b1, 1'b1);
    pc_if.clk_enable = 1'b1;
    edges(1);
    chk_state("stall_resume", 32'hBFC0_001C, 1'b0, 1'b1);

    // Reset in the delay slot cancels the pending branch.
    pulse_reset();
    pc_if.branch_taken = 1'b1; pc_if.branch_offset = 16'h0004;
    edges(1); clr();
    chk("rds_slot", {31'd0, pc_if.delay_slot}, 32'd1);
    reset = 1'b1;
    #1;
    chk_state("rds_rst", 32'hBFC0_0000, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    edges(1);
    chk_state("rds_after", 32'hBFC0_0004, 1'b0, 1'b1);

    edges(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
